alu_cmp_seq: RTL and testbench
==============================

Name: alu_cmp_seq

Overview:
Parametrised multi-cycle magnitude comparator for the ALU logic_circuits group. It generalises the combinational 8-bit comparator in three ways: operands of arbitrary width N, signed/unsigned mode, and a valid/ready handshake. It compares CHUNK bits per cycle from MSB to LSB and terminates early on the first differing chunk, so wide compares close timing on a narrow datapath. It returns registered eq/neq/lt/lte/gt/gte flags to the execute stage.

Parameters:
N, 32, operand width in bits; must be a multiple of CHUNK
CHUNK, 8, bits compared per cycle; NCHUNK = N/CHUNK (NCHUNK=1 legal)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operands/mode presented
in_ready  output  1  block can accept operands
a  input  N  operand A
b  input  N  operand B
is_signed  input  1  1 = two's-complement compare, 0 = unsigned
out_valid  output  1  flags valid
out_ready  input  1  consumer accepts flags
eq, neq, lt, lte, gt, gte  output  1 each  comparison of A against B (lt means A<B)
busy  output  1  state != IDLE

Behaviour:
- Interface: one clock, clk; reset is rst, synchronous and active-high. All state and all outputs are registered.
- Reset: state=IDLE; out_valid=0; all six flags=0; busy=0; in_ready=1 in the cycle after reset.
- States: IDLE, CMP, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture a, b and is_signed; idx=NCHUNK-1; go to CMP.
- CMP:
  - in_ready=0.
  - Each cycle compare chunk idx of the captured a and b, unsigned.
  - For idx=NCHUNK-1 with is_signed=1: invert the MSB of both chunks before comparing.
  - Chunks differ: latch lt or gt; go to DONE.
  - Chunks equal and idx==0: latch eq; go to DONE.
  - Otherwise: idx--.
- DONE:
  - out_valid=1; flags are held stable until out_valid&out_ready; then go to IDLE.
  - in_ready=0.
- Flag derivation: neq=~eq; lte=lt|eq; gte=gt|eq. Exactly one of lt/eq/gt is 1 while out_valid=1.
- Flags outside DONE: hold last value; consumers use them only when out_valid=1.
- Latency (accept edge = cycle 0):
  - CMP handles chunk NCHUNK-k in cycle k.
  - First difference at cycle k gives out_valid in cycle k+1.
  - Best case: 2 cycles. Worst case (equal operands or LSB-chunk difference): NCHUNK+1 cycles.
- Throughput: one operation outstanding. No accept in the same cycle as the out handshake; IDLE is always visited.
- Input changes on a, b or is_signed after accept have no effect.
- in_valid while busy is ignored; the upstream must hold it.
- rst in any state overrides everything: the next cycle is the reset state and the in-flight operation is discarded with no out_valid.
- Simultaneous rst and in_valid: rst wins; nothing is captured.

Test Plan:
1. N=32, unsigned, a=0x12345678, b=0x12345679 -> out_valid in cycle 5; lt=lte=neq=1, others 0.
2. Signed: a=0xFFFFFFFF, b=0x00000001 -> lt=1 in cycle 2. Same operands unsigned -> gt=gte=neq=1 in cycle 2.
3. a=b=0xA5A5A5A5 (both modes) -> eq=lte=gte=1, lt=gt=neq=0, out_valid in cycle 5; a=b=0 gives the same.
4. Backpressure: out_ready=0 for 3 cycles after out_valid.
   - out_valid and flags stay stable; in_ready=0.
   - A new in_valid (a=0, b=1) during this window is not captured until the block returns to IDLE.
   - It then yields lt=1.
5. Reset mid-op: accept a=0x01000000, b=0x02000000, assert rst in cycle 1.
   - Cycle 2: out_valid=0, all flags 0, in_ready=1, busy=0.
   - A following compare of a=5, b=3 gives gt=1 in cycle 5.
6. N=8, CHUNK=8, signed:
   - 0x80 vs 0x7F -> lt=1 in cycle 2.
   - 0x7F vs 0x80 -> gt=1.
   - Unsigned 0x80 vs 0x7F -> gt=1.
   - Back-to-back operations with out_ready=1 give one result per 3 cycles.

Source files
------------

// File: rtl/alu_cmp_seq.sv
// Multi-cycle magnitude comparator: walks the operands CHUNK bits per cycle
// from MSB to LSB and stops at the first differing chunk. Signed mode flips
// the sign bit of the top chunk so an unsigned chunk compare orders it
// correctly. Result flags are registered and held until the consumer accepts.
module alu_cmp_seq #(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         is_signed,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         eq,
  output logic         neq,
  output logic         lt,
  output logic         lte,
  output logic         gt,
  output logic         gte,
  output logic         busy
);

  localparam int NCHUNK = N / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t           state;
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic             signed_q;
  logic [IW-1:0]    idx;
  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic             top;

  // Select the current chunk pair; sign bit of the top chunk inverted in signed mode
  always_comb begin
    ca  = '0;
    cb  = '0;
    top = (idx == IW'(NCHUNK - 1));
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx == IW'(i)) begin
        ca = a_q[i*CHUNK +: CHUNK];
        cb = b_q[i*CHUNK +: CHUNK];
      end
    end
    if (top && signed_q) begin
      ca[CHUNK-1] = ~ca[CHUNK-1];
      cb[CHUNK-1] = ~cb[CHUNK-1];
    end
  end

  // Control FSM with registered handshake outputs and result flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      eq        <= 1'b0;
      neq       <= 1'b0;
      lt        <= 1'b0;
      lte       <= 1'b0;
      gt        <= 1'b0;
      gte       <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      signed_q  <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b;
            signed_q <= is_signed;
            idx      <= IW'(NCHUNK - 1);
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= CMP;
          end
        end
        CMP: begin
          if (ca != cb) begin
            eq        <= 1'b0;
            neq       <= 1'b1;
            lt        <= (ca < cb);
            lte       <= (ca < cb);
            gt        <= (ca > cb);
            gte       <= (ca > cb);
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (idx == '0) begin
            eq        <= 1'b1;
            neq       <= 1'b0;
            lt        <= 1'b0;
            lte       <= 1'b1;
            gt        <= 1'b0;
            gte       <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmp_seq.sv
// Bench for alu_cmp_seq: a 32-bit (4 chunk) and an 8-bit (1 chunk) instance,
// directed cases plus randomized operations checked against an arithmetic model.
module tb_alu_cmp_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        iv;
  logic [31:0] a;
  logic [31:0] b;
  logic        is_signed;
  logic        out_ready;

  logic iv32, rdy32, ov32, eq32, neq32, lt32, lte32, gt32, gte32, busy32;
  logic iv8, rdy8, ov8, eq8, neq8, lt8, lte8, gt8, gte8, busy8;

  logic       rdy, ov, bsy;
  logic [5:0] flags;

  int    n_tests = 0;
  int    n_fail  = 0;
  time   acc_time;
  logic [5:0] last_flags;

  always #5 clk = ~clk;

  assign iv32  = iv & ~sel;
  assign iv8   = iv & sel;
  assign rdy   = sel ? rdy8 : rdy32;
  assign ov    = sel ? ov8 : ov32;
  assign bsy   = sel ? busy8 : busy32;
  assign flags = sel ? {eq8, neq8, lt8, lte8, gt8, gte8}
                     : {eq32, neq32, lt32, lte32, gt32, gte32};

  alu_cmp_seq #(.N(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(rdy32),
    .a(a), .b(b), .is_signed(is_signed),
    .out_valid(ov32), .out_ready(out_ready),
    .eq(eq32), .neq(neq32), .lt(lt32), .lte(lte32), .gt(gt32), .gte(gte32),
    .busy(busy32)
  );

  alu_cmp_seq #(.N(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8),
    .a(a[7:0]), .b(b[7:0]), .is_signed(is_signed),
    .out_valid(ov8), .out_ready(out_ready),
    .eq(eq8), .neq(neq8), .lt(lt8), .lte(lte8), .gt(gt8), .gte(gte8),
    .busy(busy8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {eq,neq,lt,lte,gt,gte} from plain integer comparison of w-bit operands
  function automatic logic [5:0] ref_flags(input logic [31:0] av, input logic [31:0] bv,
                                           input logic s, input int w);
    longint m = longint'(1) << w;
    longint x = longint'(av) & (m - 1);
    longint y = longint'(bv) & (m - 1);
    logic e, l, g;
    if (s) begin
      if (x >= m / 2) x = x - m;
      if (y >= m / 2) y = y - m;
    end
    e = (x == y);
    l = (x < y);
    g = (x > y);
    return {e, !e, l, l | e, g, g | e};
  endfunction

  // Cycle (accept = 0) in which out_valid first shows: one cycle per chunk examined, plus one
  function automatic int ref_cycle(input logic [31:0] av, input logic [31:0] bv, input int w);
    logic [31:0] d = av ^ bv;
    int nch = w / 8;
    int p = -1;
    for (int i = w - 1; i >= 0; i--) begin
      if (d[i]) begin
        p = i;
        break;
      end
    end
    if (p < 0) return nch + 1;
    return nch - p / 8 + 1;
  endfunction

  // One operation on the selected instance; entered and left at a falling edge
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic s,
                        input int hold, input bit pend);
    int c;
    int w = sel ? 8 : 32;
    logic [5:0] fl;
    c = 0;
    while (!rdy && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("in_ready_wait", {31'd0, rdy}, 32'd1);
    a = av; b = bv; is_signed = s; iv = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    acc_time = $time;
    @(negedge clk);
    iv = 1'b0;
    a = $urandom; b = $urandom; is_signed = 1'($urandom);
    check("busy_after_accept", {31'd0, bsy}, 32'd1);
    check("ready_after_accept", {31'd0, rdy}, 32'd0);
    c = 1;
    while (!ov && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("latency", 32'(c), 32'(ref_cycle(av, bv, w)));
    fl = flags;
    last_flags = fl;
    check("flags", {26'd0, fl}, {26'd0, ref_flags(av, bv, s, w)});
    check("ready_in_done", {31'd0, rdy}, 32'd0);
    if (pend) begin
      a = 32'd0; b = 32'd1; is_signed = 1'b0; iv = 1'b1;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, ov}, 32'd1);
      check("hold_flags", {26'd0, flags}, {26'd0, fl});
      check("hold_ready", {31'd0, rdy}, 32'd0);
      check("hold_busy", {31'd0, bsy}, 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("idle_valid", {31'd0, ov}, 32'd0);
    check("idle_ready", {31'd0, rdy}, 32'd1);
    check("idle_busy", {31'd0, bsy}, 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, {31'd0, ov}, 32'd0);
    check({tag, "_flags"}, {26'd0, flags}, 32'd0);
    check({tag, "_ready"}, {31'd0, rdy}, 32'd1);
    check({tag, "_busy"}, {31'd0, bsy}, 32'd0);
  endtask

  initial begin
    time t0;
    logic [31:0] ra, rb;
    rst = 1'b1; sel = 1'b0; iv = 1'b0; a = '0; b = '0; is_signed = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("rst32");
    sel = 1'b1;
    check_reset_state("rst8");
    sel = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // 1: LSB-chunk difference, worst-case latency
    run_op(32'h12345678, 32'h12345679, 1'b0, 0, 0);
    check("t1_flags", {26'd0, last_flags}, 32'b011100);
    // 2: top-chunk difference, signed vs unsigned
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b1, 0, 0);
    check("t2_signed", {26'd0, last_flags}, 32'b011100);
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 0);
    check("t2_unsigned", {26'd0, last_flags}, 32'b010011);
    // 3: equal operands
    run_op(32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 0, 0);
    run_op(32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, 0, 0);
    check("t3_eq", {26'd0, last_flags}, 32'b100101);
    run_op(32'h0, 32'h0, 1'b0, 0, 0);
    // 4: backpressure with a request pending during the hold window
    run_op(32'h00000010, 32'h00000020, 1'b0, 3, 1);
    run_op(32'h0, 32'h1, 1'b0, 0, 0);
    check("t4_lt", {26'd0, last_flags}, 32'b011100);

    // 5: reset mid-operation discards it
    a = 32'h01000000; b = 32'h02000000; is_signed = 1'b0; iv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("midop");
    run_op(32'd5, 32'd3, 1'b0, 0, 0);
    check("t5_gt", {26'd0, last_flags}, 32'b010011);

    // reset and in_valid together: reset wins, nothing captured
    a = 32'h1; b = 32'h2; iv = 1'b1; rst = 1'b1;
    @(negedge clk);
    iv = 1'b0; rst = 1'b0;
    check_reset_state("rst_iv");
    @(negedge clk);
    check("rst_iv_idle", {31'd0, bsy}, 32'd0);

    // 6: single-chunk instance
    sel = 1'b1;
    run_op(32'h80, 32'h7F, 1'b1, 0, 0);
    check("t6_s_lt", {26'd0, last_flags}, 32'b011100);
    t0 = acc_time;
    run_op(32'h7F, 32'h80, 1'b1, 0, 0);
    check("t6_throughput", 32'(acc_time - t0), 32'd30);
    check("t6_s_gt", {26'd0, last_flags}, 32'b010011);
    run_op(32'h80, 32'h7F, 1'b0, 0, 0);
    check("t6_u_gt", {26'd0, last_flags}, 32'b010011);

    // randomized operations across both instances
    for (int n = 0; n < 60; n++) begin
      sel = 1'($urandom);
      ra = $urandom;
      case ($urandom % 4)
        0: rb = ra;
        1: rb = $urandom;
        2: rb = ra ^ (32'd1 << ($urandom % 32));
        default: rb = ra ^ (32'($urandom % 255) + 32'd1);
      endcase
      run_op(ra, rb, 1'($urandom), int'($urandom % 3), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
